// File: rtl/barcode_tx.sv
// Barcode line transmitter: one sync period, then ID[7:0] MSB first with
// period-measured low widths, then one all-high gap period.
module barcode_tx #(
  parameter int PERIOD = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] ID,
  output logic       BC,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] QTR   = CW'(PERIOD / 4);
  localparam logic [CW-1:0] HALF  = CW'(PERIOD / 2);
  localparam logic [CW-1:0] THREE = CW'(3 * PERIOD / 4);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, low_len;
  logic [2:0]    bitidx, bitidx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          period_end, bc_nxt, done_nxt;

  assign period_end = (cnt == LAST);
  assign dbg_state  = state;

  // Next-state values; BC is registered from these so the line reflects the
  // state/count it is about to hold, with no path from send or ID to BC.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitidx_nxt = bitidx;
    shift_nxt  = shift;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          state_nxt  = SYNC;
          shift_nxt  = ID;
          cnt_nxt    = '0;
          bitidx_nxt = '0;
        end
      end
      SYNC: begin
        cnt_nxt = cnt + CW'(1);
        if (period_end) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        cnt_nxt = cnt + CW'(1);
        if (period_end) begin
          cnt_nxt    = '0;
          shift_nxt  = {shift[6:0], 1'b0};
          bitidx_nxt = bitidx + 3'd1;
          if (bitidx == 3'd7) state_nxt = GAP;
        end
      end
      GAP: begin
        cnt_nxt = cnt + CW'(1);
        if (period_end) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero low length keeps the line high in IDLE and GAP.
  always_comb begin
    low_len = '0;
    case (state_nxt)
      SYNC:    low_len = HALF;
      DATA:    low_len = shift_nxt[7] ? QTR : THREE;
      default: low_len = '0;
    endcase
    bc_nxt = !(cnt_nxt < low_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shift  <= '0;
      BC     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bitidx <= bitidx_nxt;
      shift  <= shift_nxt;
      BC     <= bc_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_barcode_tx.sv
// Bench for barcode_tx: per-cycle scoreboard of {BC,busy,done} built from the
// line-encoding rules, plus low-width / fall-spacing measurements and decode.
module tb_barcode_tx;

  localparam int P = 16;
  localparam logic [2:0] IDLE_EXP = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] id = 8'h00;
  logic       bc, busy, done;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  barcode_tx #(.PERIOD(P)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .ID(id),
    .BC(bc), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] exp_q[$];
  logic [2:0] cur_exp = IDLE_EXP;

  task automatic push_frame(input logic [7:0] v);
    int low;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) low = P / 2;
      else        low = v[8-k] ? P / 4 : 3 * P / 4;
      for (int c = 0; c < P; c++) exp_q.push_back({(c >= low), 1'b1, 1'b0});
    end
    for (int c = 0; c < P; c++) exp_q.push_back(3'b110);
    exp_q.push_back(3'b101);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_exp = IDLE_EXP;
    end else begin
      if (exp_q.size() == 0 && send) push_frame(id);
      cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_EXP;
    end
  end

  // ---------------- monitor ----------------
  int widths[$];
  int falls[$];
  int cyc = 0;
  int low_run = 0;
  int done_cnt = 0;
  logic prev_bc = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) check("cycle", {29'd0, bc, busy, done}, {29'd0, cur_exp});
    if (prev_bc && !bc) falls.push_back(cyc);
    if (!bc) low_run++;
    else if (!prev_bc) begin
      widths.push_back(low_run);
      low_run = 0;
    end
    if (done) done_cnt++;
    if (busy && done) check("busy_and_done", 1, 0);
    prev_bc = bc;
  end

  // ---------------- drivers ----------------
  task automatic clear_meas();
    widths.delete();
    falls.delete();
    done_cnt = 0;
  endtask

  task automatic send_id(input logic [7:0] v);
    @(negedge clk);
    send = 1'b1;
    id = v;
    @(negedge clk);
    send = 1'b0;
    id = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 12 * P) begin
      @(negedge clk);
      n++;
    end
    if (n >= 12 * P) check("timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] decode(input int s);
    logic [7:0] v = '0;
    for (int i = 1; i <= 8; i++) v = {v[6:0], (widths[s+i] == P / 4)};
    return v;
  endfunction

  task automatic check_frame(input string tag, input int s, input logic [7:0] v);
    if (widths.size() < s + 9) check({tag, "_nwidths"}, widths.size(), s + 9);
    else begin
      check({tag, "_sync"}, widths[s], P / 2);
      check({tag, "_decode"}, decode(s), v);
    end
  endtask

  // ---------------- stimulus ----------------
  int exp_w[9] = '{8, 12, 12, 4, 12, 12, 4, 12, 4};

  initial begin
    logic [7:0] r;
    #23;
    check("reset_bc", bc, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // single 0x25 frame: exact widths, spacing, one done
    clear_meas();
    send_id(8'h25);
    wait_idle();
    check("w25_n", widths.size(), 9);
    for (int i = 0; i < 9 && i < widths.size(); i++) check("w25_width", widths[i], exp_w[i]);
    for (int i = 1; i < falls.size(); i++) check("w25_space", falls[i] - falls[i-1], P);
    check("w25_done", done_cnt, 1);

    clear_meas();
    send_id(8'hC3);
    wait_idle();
    check_frame("c3", 0, 8'hC3);

    // send pulsed mid-frame with 0xFF is ignored
    clear_meas();
    send_id(8'h25);
    repeat (38) @(negedge clk);
    send_id(8'hFF);
    wait_idle();
    check("ign_n", widths.size(), 9);
    for (int i = 0; i < 9 && i < widths.size(); i++) check("ign_width", widths[i], exp_w[i]);
    check("ign_done", done_cnt, 1);

    // asynchronous reset mid-frame
    send_id(8'($urandom));
    repeat (68) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bc", bc, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_meas();
    send_id(8'h81);
    wait_idle();
    check_frame("x81", 0, 8'h81);
    check("x81_done", done_cnt, 1);

    // send held high: back-to-back frames 10P+1 apart
    clear_meas();
    @(negedge clk);
    send = 1'b1;
    id = 8'h0F;
    repeat (3 * (10 * P + 1) - 5) @(negedge clk);
    send = 1'b0;
    wait_idle();
    check("b2b_nfalls", falls.size(), 27);
    if (falls.size() >= 27) begin
      check("b2b_gap1", falls[9] - falls[0], 10 * P + 1);
      check("b2b_gap2", falls[18] - falls[9], 10 * P + 1);
    end
    for (int f = 0; f < 3; f++) check_frame("b2b", 9 * f, 8'h0F);
    check("b2b_done", done_cnt, 3);

    // randomized frames with random idle gaps
    for (int n = 0; n < 8; n++) begin
      clear_meas();
      r = 8'($urandom);
      send_id(r);
      wait_idle();
      check_frame("rand", 0, r);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
